// File: rtl/rv64g_l2_pkg.sv
// Shared geometry and state type for the L2 array controller.
//   SETS x WAYS lines of WORDS x XLEN-bit words; each tag entry is
//   TAG_W bits with the valid flag in the MSB.
package rv64g_l2_pkg;

    localparam int unsigned SETS   = 256;
    localparam int unsigned WAYS   = 16;
    localparam int unsigned WORDS  = 8;
    localparam int unsigned TAG_W  = 50;
    localparam int unsigned XLEN   = 64;

    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned WSEL_W = $clog2(WORDS);
    localparam int unsigned BE_W   = XLEN / 8;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD,
        CMP,
        WR,
        RF_DATA
    } state_e;

endpackage

// File: rtl/rv64g_l2_tag_match.sv
// Combinational tag compare across all ways with lowest-way priority.
//   tags_flat : tag entries of every way, way 0 in the low bits
//   tag       : address tag to look for (valid bit excluded)
//   hit       : some valid way holds the tag
//   way       : lowest-numbered matching way (0 when no hit)
module rv64g_l2_tag_match
    import rv64g_l2_pkg::*;
(
    input  logic [WAYS*TAG_W-1:0] tags_flat,
    input  logic [TAG_W-2:0]      tag,
    output logic                  hit,
    output logic [WAY_W-1:0]      way
);

    always_comb begin
        hit = 1'b0;
        way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && tags_flat[w*TAG_W + TAG_W - 1] &&
                tags_flat[w*TAG_W +: TAG_W-1] == tag) begin
                hit = 1'b1;
                way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/rv64g_l2_array_ctrl.sv
// Sequencer/arbiter that owns every control input of the L2 tag/data arrays.
//   - After reset, sweeps all SETS*WAYS tag entries to zero (invalid).
//   - Serves single-word lookups (read, or byte-masked write on hit).
//   - Serves 8-beat line refills; refill start beats a lookup in IDLE.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   init_done_o                   sticky sweep-complete flag
//   req_*                         lookup request (valid/ready handshake)
//   resp_*                        one-cycle lookup response
//   rf_req_*, rf_index/tag/way_i  refill start handshake and target
//   rf_data_*                     refill beat handshake and data
//   arr_*_o                       array address, enables, write values
//   arr_tag_flat_i/rdata_flat_i   synchronous array read data (all ways)
//   arr_rdata_sel_i               array data of the selected way
module rv64g_l2_array_ctrl
    import rv64g_l2_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   init_done_o,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [IDX_W-1:0]       req_index_i,
    input  logic [TAG_W-2:0]       req_tag_i,
    input  logic [WSEL_W-1:0]      req_word_i,
    input  logic                   req_we_i,
    input  logic [BE_W-1:0]        req_be_i,
    input  logic [XLEN-1:0]        req_wdata_i,
    output logic                   resp_valid_o,
    output logic                   resp_hit_o,
    output logic [WAY_W-1:0]       resp_way_o,
    output logic [XLEN-1:0]        resp_rdata_o,
    input  logic                   rf_req_valid_i,
    output logic                   rf_req_ready_o,
    input  logic [IDX_W-1:0]       rf_index_i,
    input  logic [TAG_W-2:0]       rf_tag_i,
    input  logic [WAY_W-1:0]       rf_way_i,
    input  logic                   rf_data_valid_i,
    output logic                   rf_data_ready_o,
    input  logic [XLEN-1:0]        rf_data_i,
    output logic [IDX_W-1:0]       arr_index_o,
    output logic [WSEL_W-1:0]      arr_word_sel_o,
    output logic [WAY_W-1:0]       arr_way_sel_o,
    output logic                   arr_data_we_o,
    output logic                   arr_tag_we_o,
    output logic [BE_W-1:0]        arr_be_o,
    output logic [TAG_W-1:0]       arr_tag_o,
    output logic [XLEN-1:0]        arr_wdata_o,
    input  logic [XLEN-1:0]        arr_rdata_sel_i,
    input  logic [WAYS*TAG_W-1:0]  arr_tag_flat_i,
    input  logic [WAYS*XLEN-1:0]   arr_rdata_flat_i
);

    state_e                   state_q;
    // Sweep writes start one cycle after reset release so that every
    // output, including the tag write enable, is 0 while reset is held.
    logic                     arm_q;
    logic [IDX_W+WAY_W-1:0]   sweep_q;   // {set, way}, way increments fastest
    logic                     init_done_q;

    logic [IDX_W-1:0]         req_index_q;
    logic [TAG_W-2:0]         req_tag_q;
    logic [WSEL_W-1:0]        req_word_q;
    logic                     req_we_q;
    logic [BE_W-1:0]          req_be_q;
    logic [XLEN-1:0]          req_wdata_q;
    logic [WAY_W-1:0]         hit_way_q;

    logic [IDX_W-1:0]         rf_index_q;
    logic [TAG_W-2:0]         rf_tag_q;
    logic [WAY_W-1:0]         rf_way_q;
    logic [WSEL_W-1:0]        beat_q;

    logic                     cmp_hit;
    logic [WAY_W-1:0]         cmp_way;
    logic                     rf_take, req_take, beat_take, last_beat;

    // Read data is taken from the all-ways bus; the selected-way port is unused.
    logic unused_rdata_sel;
    assign unused_rdata_sel = ^arr_rdata_sel_i;

    rv64g_l2_tag_match u_tag_match (
        .tags_flat (arr_tag_flat_i),
        .tag       (req_tag_q),
        .hit       (cmp_hit),
        .way       (cmp_way)
    );

    assign init_done_o     = init_done_q;
    assign rf_req_ready_o  = (state_q == IDLE);
    assign req_ready_o     = (state_q == IDLE) && !rf_req_valid_i;
    assign rf_data_ready_o = (state_q == RF_DATA);
    assign rf_take         = rf_req_valid_i && rf_req_ready_o;
    assign req_take        = req_valid_i && req_ready_o;
    assign beat_take       = rf_data_valid_i && rf_data_ready_o;
    assign last_beat       = (beat_q == WSEL_W'(WORDS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            arm_q       <= 1'b0;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
            req_index_q <= '0;
            req_tag_q   <= '0;
            req_word_q  <= '0;
            req_we_q    <= 1'b0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
            hit_way_q   <= '0;
            rf_index_q  <= '0;
            rf_tag_q    <= '0;
            rf_way_q    <= '0;
            beat_q      <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    arm_q <= 1'b1;
                    if (arm_q) begin
                        sweep_q <= sweep_q + 1'b1;
                        if (&sweep_q) begin
                            state_q     <= IDLE;
                            init_done_q <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (rf_take) begin
                        rf_index_q <= rf_index_i;
                        rf_tag_q   <= rf_tag_i;
                        rf_way_q   <= rf_way_i;
                        beat_q     <= '0;
                        state_q    <= RF_DATA;
                    end else if (req_take) begin
                        req_index_q <= req_index_i;
                        req_tag_q   <= req_tag_i;
                        req_word_q  <= req_word_i;
                        req_we_q    <= req_we_i;
                        req_be_q    <= req_be_i;
                        req_wdata_q <= req_wdata_i;
                        state_q     <= RD;
                    end
                end
                RD:  state_q <= CMP;
                CMP: begin
                    if (req_we_q && cmp_hit) begin
                        hit_way_q <= cmp_way;
                        state_q   <= WR;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WR:  state_q <= IDLE;
                RF_DATA: begin
                    if (beat_take) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    always_comb begin
        arr_index_o    = '0;
        arr_word_sel_o = '0;
        arr_way_sel_o  = '0;
        arr_data_we_o  = 1'b0;
        arr_tag_we_o   = 1'b0;
        arr_be_o       = '0;
        arr_tag_o      = '0;
        arr_wdata_o    = '0;
        resp_valid_o   = 1'b0;
        resp_hit_o     = 1'b0;
        resp_way_o     = '0;
        resp_rdata_o   = '0;
        case (state_q)
            INIT: begin
                arr_tag_we_o                  = arm_q;
                {arr_index_o, arr_way_sel_o}  = sweep_q;
            end
            RD, CMP: begin
                arr_index_o    = req_index_q;
                arr_word_sel_o = req_word_q;
                // A write hit defers its response to the WR cycle.
                if (state_q == CMP && !(req_we_q && cmp_hit)) begin
                    resp_valid_o = 1'b1;
                    resp_hit_o   = cmp_hit;
                    resp_way_o   = cmp_way;
                    if (!req_we_q && cmp_hit) begin
                        resp_rdata_o = arr_rdata_flat_i[XLEN*cmp_way +: XLEN];
                    end
                end
            end
            WR: begin
                arr_index_o    = req_index_q;
                arr_word_sel_o = req_word_q;
                arr_way_sel_o  = hit_way_q;
                arr_data_we_o  = 1'b1;
                arr_be_o       = req_be_q;
                arr_wdata_o    = req_wdata_q;
                resp_valid_o   = 1'b1;
                resp_hit_o     = 1'b1;
                resp_way_o     = hit_way_q;
            end
            RF_DATA: begin
                arr_index_o    = rf_index_q;
                arr_word_sel_o = beat_q;
                arr_way_sel_o  = rf_way_q;
                arr_be_o       = '1;
                arr_wdata_o    = rf_data_i;
                arr_data_we_o  = rf_data_valid_i;
                arr_tag_we_o   = rf_data_valid_i && last_beat;
                arr_tag_o      = {1'b1, rf_tag_q};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv64g_l2_array_ctrl.sv
module tb_rv64g_l2_array_ctrl;
    import rv64g_l2_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   init_done_o;
    logic                   req_valid_i = 1'b0;
    logic                   req_ready_o;
    logic [IDX_W-1:0]       req_index_i = '0;
    logic [TAG_W-2:0]       req_tag_i = '0;
    logic [WSEL_W-1:0]      req_word_i = '0;
    logic                   req_we_i = 1'b0;
    logic [BE_W-1:0]        req_be_i = '0;
    logic [XLEN-1:0]        req_wdata_i = '0;
    logic                   resp_valid_o;
    logic                   resp_hit_o;
    logic [WAY_W-1:0]       resp_way_o;
    logic [XLEN-1:0]        resp_rdata_o;
    logic                   rf_req_valid_i = 1'b0;
    logic                   rf_req_ready_o;
    logic [IDX_W-1:0]       rf_index_i = '0;
    logic [TAG_W-2:0]       rf_tag_i = '0;
    logic [WAY_W-1:0]       rf_way_i = '0;
    logic                   rf_data_valid_i = 1'b0;
    logic                   rf_data_ready_o;
    logic [XLEN-1:0]        rf_data_i = '0;
    logic [IDX_W-1:0]       arr_index_o;
    logic [WSEL_W-1:0]      arr_word_sel_o;
    logic [WAY_W-1:0]       arr_way_sel_o;
    logic                   arr_data_we_o;
    logic                   arr_tag_we_o;
    logic [BE_W-1:0]        arr_be_o;
    logic [TAG_W-1:0]       arr_tag_o;
    logic [XLEN-1:0]        arr_wdata_o;
    logic [XLEN-1:0]        arr_rdata_sel_i;
    logic [WAYS*TAG_W-1:0]  arr_tag_flat_i;
    logic [WAYS*XLEN-1:0]   arr_rdata_flat_i;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    rv64g_l2_array_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .init_done_o(init_done_o),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_index_i(req_index_i), .req_tag_i(req_tag_i), .req_word_i(req_word_i),
        .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o),
        .resp_way_o(resp_way_o), .resp_rdata_o(resp_rdata_o),
        .rf_req_valid_i(rf_req_valid_i), .rf_req_ready_o(rf_req_ready_o),
        .rf_index_i(rf_index_i), .rf_tag_i(rf_tag_i), .rf_way_i(rf_way_i),
        .rf_data_valid_i(rf_data_valid_i), .rf_data_ready_o(rf_data_ready_o),
        .rf_data_i(rf_data_i),
        .arr_index_o(arr_index_o), .arr_word_sel_o(arr_word_sel_o),
        .arr_way_sel_o(arr_way_sel_o), .arr_data_we_o(arr_data_we_o),
        .arr_tag_we_o(arr_tag_we_o), .arr_be_o(arr_be_o), .arr_tag_o(arr_tag_o),
        .arr_wdata_o(arr_wdata_o), .arr_rdata_sel_i(arr_rdata_sel_i),
        .arr_tag_flat_i(arr_tag_flat_i), .arr_rdata_flat_i(arr_rdata_flat_i)
    );

    always #5 clk_i = ~clk_i;

    logic any_out;
    assign any_out = |{init_done_o, req_ready_o, resp_valid_o, resp_hit_o, resp_way_o,
                       resp_rdata_o, rf_req_ready_o, rf_data_ready_o, arr_index_o,
                       arr_word_sel_o, arr_way_sel_o, arr_data_we_o, arr_tag_we_o,
                       arr_be_o, arr_tag_o, arr_wdata_o};

    // Array emulation: writes commit at the edge, reads return one cycle later.
    logic [TAG_W-1:0] emu_tag  [SETS*WAYS];
    logic [XLEN-1:0]  emu_data [SETS*WAYS*WORDS];
    logic             scramble = 1'b1;

    always @(posedge clk_i) begin : emu
        int unsigned b;
        if (scramble) begin
            for (int unsigned i = 0; i < SETS*WAYS; i++)
                emu_tag[i] <= {1'b1, 49'({$urandom, $urandom})};
        end else begin
            b = arr_index_o * WAYS;
            for (int unsigned w = 0; w < WAYS; w++) begin
                arr_tag_flat_i[w*TAG_W +: TAG_W]  <= emu_tag[b+w];
                arr_rdata_flat_i[w*XLEN +: XLEN]  <= emu_data[(b+w)*WORDS + arr_word_sel_o];
            end
            arr_rdata_sel_i <= emu_data[(b+arr_way_sel_o)*WORDS + arr_word_sel_o];
            if (arr_tag_we_o) emu_tag[b+arr_way_sel_o] <= arr_tag_o;
            if (arr_data_we_o)
                for (int unsigned j = 0; j < BE_W; j++)
                    if (arr_be_o[j])
                        emu_data[(b+arr_way_sel_o)*WORDS + arr_word_sel_o][8*j +: 8] <= arr_wdata_o[8*j +: 8];
        end
    end

    // Reference model: cache contents as seen by the request/refill paths.
    logic [TAG_W-1:0] mdl_tag  [SETS*WAYS];
    logic [XLEN-1:0]  mdl_data [SETS*WAYS*WORDS];

    task automatic model_clear();
        for (int unsigned i = 0; i < SETS*WAYS; i++) mdl_tag[i] = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        checks++;
        if (any_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: some output nonzero (or=%b), required 0", any_out);
        end
    endtask

    task automatic test_init();
        int unsigned cyc, writes, order_bad, rdy_bad, first_we, last_we, nz;
        cyc = 0; writes = 0; order_bad = 0; rdy_bad = 0; first_we = 0; last_we = 0; nz = 0;
        @(negedge clk_i);
        while (!init_done_o && cyc < 6000) begin
            if (arr_tag_we_o) begin
                if (arr_tag_o !== '0 || {arr_index_o, arr_way_sel_o} !== (IDX_W+WAY_W)'(writes))
                    order_bad++;
                if (writes == 0) first_we = cyc;
                writes++;
                last_we = cyc;
            end
            if (req_ready_o || rf_req_ready_o) rdy_bad++;
            cyc++;
            @(negedge clk_i);
        end
        checks++;
        if (init_done_o !== 1'b1) begin
            fails++; $display("FAIL init_done: got %b after %0d cycles, required 1", init_done_o, cyc);
        end
        checks++;
        if (writes != SETS*WAYS || last_we - first_we + 1 != SETS*WAYS) begin
            fails++; $display("FAIL init_sweep_len: %0d writes over %0d cycles, required 4096", writes, last_we - first_we + 1);
        end
        checks++;
        if (order_bad != 0) begin
            fails++; $display("FAIL init_sweep_order: %0d bad entries, required 0", order_bad);
        end
        checks++;
        if (rdy_bad != 0) begin
            fails++; $display("FAIL init_ready: ready high in %0d cycles, required 0", rdy_bad);
        end
        checks++;
        if (cyc != last_we + 1 || arr_tag_we_o !== 1'b0 || rf_req_ready_o !== 1'b1) begin
            fails++; $display("FAIL init_done_timing: done at cycle %0d we=%b rdy=%b, required cycle %0d we=0 rdy=1",
                              cyc, arr_tag_we_o, rf_req_ready_o, last_we + 1);
        end
        for (int unsigned i = 0; i < SETS*WAYS; i++) if (emu_tag[i] !== '0) nz++;
        checks++;
        if (nz != 0) begin
            fails++; $display("FAIL init_tags_cleared: %0d entries nonzero, required 0", nz);
        end
        @(posedge clk_i); #1;
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic refill(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way,
                          input logic [TAG_W-2:0] tg, input logic [WORDS*XLEN-1:0] line,
                          input logic chk_blocked, input int unsigned nbeats);
        int unsigned n, bad, blk;
        n = 0; bad = 0; blk = 0;
        rf_req_valid_i = 1'b1; rf_index_i = idx; rf_way_i = way; rf_tag_i = tg;
        @(negedge clk_i);
        while (!rf_req_ready_o && n < 64) begin n++; @(negedge clk_i); end
        checks++;
        if (rf_req_ready_o !== 1'b1) begin
            fails++; $display("FAIL rf_handshake: rf_req_ready_o=%b after %0d cycles, required 1", rf_req_ready_o, n);
        end
        if (chk_blocked && req_ready_o) blk++;
        @(posedge clk_i); #1;
        rf_req_valid_i = 1'b0;
        for (int unsigned k = 0; k < nbeats; k++) begin
            for (int unsigned s = $urandom_range(0, 2); s > 0; s--) begin
                @(negedge clk_i);
                if (arr_data_we_o || arr_tag_we_o || !rf_data_ready_o) bad++;
                if (chk_blocked && req_ready_o) blk++;
                @(posedge clk_i); #1;
            end
            rf_data_valid_i = 1'b1;
            rf_data_i = line[XLEN*k +: XLEN];
            @(negedge clk_i);
            if (rf_data_ready_o !== 1'b1 || arr_data_we_o !== 1'b1 || arr_index_o !== idx ||
                arr_word_sel_o !== WSEL_W'(k) || arr_way_sel_o !== way || arr_be_o !== '1 ||
                arr_wdata_o !== line[XLEN*k +: XLEN] || arr_tag_we_o !== (k == WORDS-1) ||
                (k == WORDS-1 && arr_tag_o !== {1'b1, tg}))
                bad++;
            if (chk_blocked && req_ready_o) blk++;
            @(posedge clk_i); #1;
            rf_data_valid_i = 1'b0;
        end
        checks++;
        if (bad != 0) begin
            fails++; $display("FAIL rf_beats: %0d bad beat/stall cycles at idx %0h way %0d, required 0", bad, idx, way);
        end
        if (chk_blocked) begin
            checks++;
            if (blk != 0) begin
                fails++; $display("FAIL rf_priority: req_ready_o high in %0d refill cycles, required 0", blk);
            end
        end
        if (nbeats == WORDS) begin
            mdl_tag[idx*WAYS + way] = {1'b1, tg};
            for (int unsigned k = 0; k < WORDS; k++)
                mdl_data[(idx*WAYS + way)*WORDS + k] = line[XLEN*k +: XLEN];
        end
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic lookup(input logic [IDX_W-1:0] idx, input logic [TAG_W-2:0] tg,
                          input logic [WSEL_W-1:0] wsel, input logic we,
                          input logic [BE_W-1:0] be, input logic [XLEN-1:0] wd,
                          output logic [XLEN-1:0] rd);
        logic e_hit, got, g_hit;
        logic [WAY_W-1:0] e_way, g_way;
        logic [XLEN-1:0] e_rd, g_rd;
        int unsigned e_lat, lat, n, n_we, wr_bad;
        e_hit = 1'b0; e_way = '0;
        for (int unsigned w = 0; w < WAYS; w++)
            if (!e_hit && mdl_tag[idx*WAYS + w] === {1'b1, tg}) begin
                e_hit = 1'b1; e_way = WAY_W'(w);
            end
        e_rd  = (e_hit && !we) ? mdl_data[(idx*WAYS + e_way)*WORDS + wsel] : '0;
        e_lat = (e_hit && we) ? 3 : 2;
        req_valid_i = 1'b1; req_index_i = idx; req_tag_i = tg; req_word_i = wsel;
        req_we_i = we; req_be_i = be; req_wdata_i = wd;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 64) begin n++; @(negedge clk_i); end
        checks++;
        if (req_ready_o !== 1'b1) begin
            fails++; $display("FAIL req_handshake: req_ready_o=%b after %0d cycles, required 1", req_ready_o, n);
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        got = 1'b0; lat = 0; n_we = 0; wr_bad = 0; g_hit = 1'b0; g_way = '0; g_rd = '0;
        for (int unsigned c = 1; c <= 6 && !got; c++) begin
            @(negedge clk_i);
            if (arr_data_we_o) begin
                n_we++;
                if (arr_index_o !== idx || arr_word_sel_o !== wsel || arr_way_sel_o !== e_way ||
                    arr_be_o !== be || arr_wdata_o !== wd) wr_bad++;
            end
            if (resp_valid_o) begin
                got = 1'b1; lat = c; g_hit = resp_hit_o; g_way = resp_way_o; g_rd = resp_rdata_o;
            end
        end
        checks++;
        if (lat != e_lat) begin
            fails++; $display("FAIL resp_latency: idx %0h tag %0h we %b got %0d cycles, required %0d", idx, tg, we, lat, e_lat);
        end
        checks++;
        if (g_hit !== e_hit || (e_hit && g_way !== e_way)) begin
            fails++; $display("FAIL resp_hit_way: got hit=%b way=%0d, required hit=%b way=%0d", g_hit, g_way, e_hit, e_way);
        end
        checks++;
        if (g_rd !== e_rd) begin
            fails++; $display("FAIL resp_rdata: got %h, required %h", g_rd, e_rd);
        end
        checks++;
        if (n_we != ((e_hit && we) ? 1 : 0) || wr_bad != 0) begin
            fails++; $display("FAIL lookup_write: %0d array writes (%0d malformed), required %0d", n_we, wr_bad, (e_hit && we) ? 1 : 0);
        end
        if (e_hit && we)
            for (int unsigned j = 0; j < BE_W; j++)
                if (be[j]) mdl_data[(idx*WAYS + e_way)*WORDS + wsel][8*j +: 8] = wd[8*j +: 8];
        rd = g_rd;
        @(posedge clk_i); #1;
    endtask

    task automatic test_refill_read();
        logic [WORDS*XLEN-1:0] line;
        logic [XLEN-1:0] rd;
        for (int unsigned k = 0; k < WORDS; k++) line[XLEN*k +: XLEN] = 64'h1000 + 64'(k);
        refill(8'h10, 4'd5, 49'h0ABC, line, 1'b0, WORDS);
        lookup(8'h10, 49'h0ABC, 3'd2, 1'b0, '0, '0, rd);
        checks++;
        if (rd !== 64'h1002) begin
            fails++; $display("FAIL refill_readback: got %h, required %h", rd, 64'h1002);
        end
    endtask

    task automatic test_write_hit();
        logic [XLEN-1:0] rd;
        lookup(8'h10, 49'h0ABC, 3'd2, 1'b1, 8'hFF, 64'hDEADBEEFCAFEBABE, rd);
        lookup(8'h10, 49'h0ABC, 3'd2, 1'b1, 8'h0F, 64'h0000000011111111, rd);
        lookup(8'h10, 49'h0ABC, 3'd2, 1'b0, '0, '0, rd);
        checks++;
        if (rd !== 64'hDEADBEEF11111111) begin
            fails++; $display("FAIL write_merge: got %h, required %h", rd, 64'hDEADBEEF11111111);
        end
    endtask

    task automatic test_miss();
        logic [XLEN-1:0] rd;
        lookup(8'h10, 49'h0ABD, 3'd2, 1'b0, '0, '0, rd);
        lookup(8'h10, 49'h0ABD, 3'd2, 1'b1, 8'hFF, 64'h5555, rd);
        lookup(8'h10, '0, 3'd0, 1'b0, '0, '0, rd);
    endtask

    task automatic test_lowest_way();
        logic [WORDS*XLEN-1:0] line;
        logic [XLEN-1:0] rd;
        for (int unsigned k = 0; k < WORDS; k++) line[XLEN*k +: XLEN] = 64'h9000 + 64'(k);
        refill(8'h10, 4'd9, 49'h0ABC, line, 1'b0, WORDS);
        lookup(8'h10, 49'h0ABC, 3'd4, 1'b0, '0, '0, rd);
        for (int unsigned k = 0; k < WORDS; k++) line[XLEN*k +: XLEN] = 64'hA000 + 64'(k);
        refill(8'h10, 4'd15, 49'h0ABC, line, 1'b0, WORDS);
        lookup(8'h10, 49'h0ABC, 3'd5, 1'b0, '0, '0, rd);
    endtask

    task automatic test_back_to_back();
        logic [WORDS*XLEN-1:0] line;
        logic [XLEN-1:0] rd;
        for (int unsigned k = 0; k < WORDS; k++) line[XLEN*k +: XLEN] = {$urandom, $urandom};
        req_valid_i = 1'b1; req_index_i = 8'h10; req_tag_i = 49'h0ABC; req_word_i = 3'd3;
        req_we_i = 1'b0; req_be_i = '0; req_wdata_i = '0;
        refill(8'h21, 4'd2, 49'h0777, line, 1'b1, WORDS);
        lookup(8'h10, 49'h0ABC, 3'd3, 1'b0, '0, '0, rd);
    endtask

    task automatic test_random();
        logic [WORDS*XLEN-1:0] line;
        logic [XLEN-1:0] rd;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-2:0] tg;
        for (int unsigned i = 0; i < 60; i++) begin
            idx = 8'h30 + IDX_W'($urandom_range(0, 3));
            tg  = 49'h100 + 49'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin
                    for (int unsigned k = 0; k < WORDS; k++) line[XLEN*k +: XLEN] = {$urandom, $urandom};
                    refill(idx, WAY_W'($urandom_range(0, WAYS-1)), tg, line, 1'b0, WORDS);
                end
                1: lookup(idx, tg, WSEL_W'($urandom_range(0, WORDS-1)), 1'b0, '0, '0, rd);
                2: lookup(idx, tg, WSEL_W'($urandom_range(0, WORDS-1)), 1'b1,
                          BE_W'($urandom), {$urandom, $urandom}, rd);
                default: lookup(idx, 49'h200 + 49'($urandom_range(0, 7)),
                                WSEL_W'($urandom_range(0, WORDS-1)), 1'b0, '0, '0, rd);
            endcase
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [WORDS*XLEN-1:0] line;
        logic [XLEN-1:0] rd;
        for (int unsigned k = 0; k < WORDS; k++) line[XLEN*k +: XLEN] = {$urandom, $urandom};
        refill(8'h40, 4'd1, 49'h0555, line, 1'b0, 3);
        rf_data_valid_i = 1'b1;
        rf_data_i = line[XLEN*3 +: XLEN];
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (any_out !== 1'b0) begin
            fails++; $display("FAIL reset_mid_refill: some output nonzero (or=%b), required 0", any_out);
        end
        rf_data_valid_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        test_init();
        lookup(8'h10, 49'h0ABC, 3'd2, 1'b0, '0, '0, rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        scramble = 1'b0;
        test_reset();
        #3;
        rst_ni = 1'b1;
        test_init();
        test_refill_read();
        test_write_hit();
        test_miss();
        test_lowest_way();
        test_back_to_back();
        test_random();
        test_reset_mid_refill();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
